vdp_step_seq: RTL and testbench



---
 rtl/vdp_step_seq.sv | 217 +++++++++++++++++++++
 tb/tb_vdp_step_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_step_seq.sv
// vdp_step_seq: run sequencer placed in front of vdp_top.
// For each step it issues a one-cycle start pulse, waits for done, and
// captures the signed Q16.16 x result into a small FWFT FIFO. The FIFO is
// streamed out on a valid/ready port with the step index and a last flag.
// Rising zero crossings of x are counted per run.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   run                   level; a rising edge while idle starts a run
//   abort                 pulse; terminates the current run, flushes the FIFO
//   num_steps             steps per run, sampled at run start (0 = empty run)
//   vdp_start/vdp_done    start pulse to and done level from vdp_top
//   vdp_x                 x result from vdp_top
//   m_valid/m_ready       output stream handshake
//   m_data/m_index/m_last head sample, its step number, last-step flag
//   busy                  sequencer is not idle
//   run_done              one-cycle pulse at the end of every run
//   zc_count              rising zero crossings of x in the current/last run
module vdp_step_seq #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_steps,
  output logic              vdp_start,
  input  logic              vdp_done,
  input  logic [DATA_W-1:0] vdp_x,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  m_index,
  output logic              m_last,
  output logic              busy,
  output logic              run_done,
  output logic [CNT_W-1:0]  zc_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + CNT_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_GUARD  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [2:0]       state_r, state_s, nxt_s;
  logic             run_prev_r;
  logic [CNT_W-1:0] steps_r, step_r;
  logic             prev_neg_r;    // only the sign of the previous x matters
  logic [EW-1:0]    mem_r [DEPTH];
  logic [EW-1:0]    head_r, head_s, entry_s;
  logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic             run_rise_s, abort_s, full_s, pop_s, push_s, empty_next_s;
  logic             last_step_s;

  // Handshake decode and next FIFO pointers; abort empties the FIFO at once.
  always_comb begin
    run_rise_s   = run & ~run_prev_r;
    abort_s      = abort & (state_r != S_IDLE);
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s        = m_valid & m_ready;
    last_step_s  = (step_r == (steps_r - CNT_ONE));
    // A done coinciding with abort is discarded.
    push_s       = (state_r == S_WAIT) & vdp_done & ~abort_s;
    entry_s      = {vdp_x, step_r, last_step_s};
    if (abort_s) begin
      wr_ptr_s = wr_ptr_r;
      rd_ptr_s = wr_ptr_r;
    end else begin
      wr_ptr_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    end
    empty_next_s = (wr_ptr_s == rd_ptr_s);
  end

  // Next head entry: bypass the incoming sample when it becomes the head.
  always_comb begin
    if (push_s && (rd_ptr_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      head_s = entry_s;
    end else begin
      head_s = mem_r[rd_ptr_s[AW-1:0]];
    end
  end

  // Sequencer next-state logic; abort overrides every active state.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (run_rise_s) begin
          if (num_steps == {CNT_W{1'b0}}) begin
            nxt_s = S_FINISH;
          end else begin
            nxt_s = S_ISSUE;
          end
        end else begin
          nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (full_s) begin
          nxt_s = S_ISSUE;
        end else begin
          nxt_s = S_GUARD;
        end
      end
      // done may still be high from the previous step here, so skip it.
      S_GUARD: nxt_s = S_WAIT;
      S_WAIT: begin
        if (vdp_done) begin
          if ((step_r + CNT_ONE) == steps_r) begin
            nxt_s = S_DRAIN;
          end else begin
            nxt_s = S_ISSUE;
          end
        end else begin
          nxt_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (empty_next_s) begin
          nxt_s = S_FINISH;
        end else begin
          nxt_s = S_DRAIN;
        end
      end
      S_FINISH: nxt_s = S_IDLE;
      default:  nxt_s = S_IDLE;
    endcase
    if (abort_s && (state_r != S_FINISH)) begin
      state_s = S_FINISH;
    end else begin
      state_s = nxt_s;
    end
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      run_prev_r <= 1'b0;
      vdp_start  <= 1'b0;
      busy       <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      state_r    <= state_s;
      run_prev_r <= run;
      vdp_start  <= (state_s == S_GUARD);   // GUARD is only entered from ISSUE
      busy       <= (state_s != S_IDLE);
      run_done   <= (state_s == S_FINISH);
    end
  end

  // Run parameters, step counter and saturating zero-crossing counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steps_r    <= {CNT_W{1'b0}};
      step_r     <= {CNT_W{1'b0}};
      prev_neg_r <= 1'b0;
      zc_count   <= {CNT_W{1'b0}};
    end else if ((state_r == S_IDLE) && run_rise_s) begin
      steps_r    <= num_steps;
      step_r     <= {CNT_W{1'b0}};
      prev_neg_r <= 1'b0;
      zc_count   <= {CNT_W{1'b0}};
    end else if (push_s) begin
      step_r     <= step_r + CNT_ONE;
      prev_neg_r <= vdp_x[DATA_W-1];
      if (prev_neg_r && !vdp_x[DATA_W-1] && (zc_count != {CNT_W{1'b1}})) begin
        zc_count <= zc_count + CNT_ONE;
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
    end
  end

  // FIFO pointers and registered head; head holds while valid and not ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      m_valid  <= 1'b0;
      head_r   <= {EW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      m_valid  <= ~empty_next_s;
      if (!empty_next_s) begin
        head_r <= head_s;
      end
    end
  end

  assign m_data  = head_r[EW-1 -: DATA_W];
  assign m_index = head_r[CNT_W:1];
  assign m_last  = head_r[0];

endmodule

// File: tb/tb_vdp_step_seq.sv
module tb_vdp_step_seq;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n, run, abort, m_ready;
  logic [CNT_W-1:0]  num_steps;
  logic              vdp_start, vdp_done, m_valid, m_last, busy, run_done;
  logic [DATA_W-1:0] vdp_x = '0;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_index, zc_count;

  int checks = 0;
  int errors = 0;

  vdp_step_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .abort(abort),
    .num_steps(num_steps), .vdp_start(vdp_start), .vdp_done(vdp_done),
    .vdp_x(vdp_x), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy), .run_done(run_done),
    .zc_count(zc_count)
  );

  always #5 clk = ~clk;

  // vdp_top model: x for start number k is xs[k]; done after a random latency
  logic [DATA_W-1:0] xs [0:1023];
  int start_cnt = 0;
  int lat_lo = 4;
  int lat_hi = 4;
  bit sticky = 1'b0;
  int cnt_m  = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vdp_done <= 1'b0;
      cnt_m    <= 0;
    end else if (vdp_start) begin
      vdp_done  <= 1'b0;
      cnt_m     <= int'($urandom_range(lat_hi, lat_lo));
      vdp_x     <= xs[start_cnt];
      start_cnt <= start_cnt + 1;
    end else if (cnt_m == 1) begin
      vdp_done <= 1'b1;
      cnt_m    <= 0;
    end else begin
      if (cnt_m > 1) cnt_m <= cnt_m - 1;
      if (!sticky) vdp_done <= 1'b0;
    end
  end

  // Output monitor: records every accepted sample and run_done/valid activity
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] obs_d [$];
  logic [CNT_W-1:0]  obs_i [$];
  bit                obs_l [$];
  int last_pop_cyc = 0;
  int done_pulses = 0;
  int done_cyc = 0;
  int valid_cyc = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_valid && m_ready) begin
        obs_d.push_back(m_data);
        obs_i.push_back(m_index);
        obs_l.push_back(m_last);
        last_pop_cyc <= cyc;
      end
      if (run_done) begin
        done_pulses <= done_pulses + 1;
        done_cyc    <= cyc;
      end
      if (m_valid) valid_cyc <= valid_cyc + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_run(input int n);
    num_steps = n[CNT_W-1:0];
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick(1);
      if (done_pulses > base) ok = 1'b1;
    end
  endtask

  // Reference zero-crossing count of a step sequence
  function automatic int zc_model(input int base, input int n);
    int prev = 0;
    int zc = 0;
    for (int i = 0; i < n; i++) begin
      if (prev < 0 && $signed(xs[base+i]) >= 0) zc++;
      prev = $signed(xs[base+i]);
    end
    return zc;
  endfunction

  task automatic test_reset();
    int sbase;
    reset_n = 1'b0; run = 1'b0; abort = 1'b0; m_ready = 1'b0; num_steps = '0;
    tick(3);
    checks++;
    if ({vdp_start, m_valid, m_last, busy, run_done} !== 5'b0 || m_data !== '0 ||
        m_index !== '0 || zc_count !== '0) begin
      errors++;
      $display("FAIL reset_values: start=%b valid=%b last=%b busy=%b done=%b data=%h idx=%0d zc=%0d, required all zero",
               vdp_start, m_valid, m_last, busy, run_done, m_data, m_index, zc_count);
    end
    reset_n = 1'b1;
    tick(2);
    // reset asserted while waiting for done in the middle of a run
    sbase = start_cnt;
    for (int i = 0; i < 5; i++) xs[sbase+i] = 32'h1234_5678 + i;
    lat_lo = 6; lat_hi = 6; m_ready = 1'b1;
    pulse_run(5);
    for (int k = 0; k < 100 && (start_cnt - sbase) < 2; k++) tick(1);
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({vdp_start, m_valid, m_last, busy, run_done} !== 5'b0 || m_data !== '0 ||
        m_index !== '0 || zc_count !== '0) begin
      errors++;
      $display("FAIL reset_async: start=%b valid=%b last=%b busy=%b done=%b data=%h idx=%0d, required all zero",
               vdp_start, m_valid, m_last, busy, run_done, m_data, m_index);
    end
    tick(1);
    reset_n = 1'b1;
    sbase = start_cnt;
    tick(15);
    checks++;
    if (start_cnt != sbase || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: starts=%0d valid=%b busy=%b, required 0 0 0",
               start_cnt - sbase, m_valid, busy);
    end
  endtask

  task automatic test_basic();
    int sbase, obase, dbase;
    bit ok;
    sbase = start_cnt; obase = obs_d.size(); dbase = done_pulses;
    xs[sbase+0] = 32'hFFFF_0000; xs[sbase+1] = 32'hFFFF_8000; xs[sbase+2] = 32'h0000_8000;
    xs[sbase+3] = 32'h0001_0000; xs[sbase+4] = 32'hFFFF_C000;
    lat_lo = 4; lat_hi = 4; sticky = 1'b0; m_ready = 1'b1;
    pulse_run(5);
    wait_done(dbase, 300, ok);
    tick(3);
    checks++;
    if (!ok || (start_cnt - sbase) != 5 || (obs_d.size() - obase) != 5) begin
      errors++;
      $display("FAIL basic_counts: done=%b starts=%0d samples=%0d, required 1 5 5",
               ok, start_cnt - sbase, obs_d.size() - obase);
    end
    for (int i = 0; i < 5 && (obase + i) < obs_d.size(); i++) begin
      checks++;
      if (obs_d[obase+i] !== xs[sbase+i] || obs_i[obase+i] !== CNT_W'(i) || obs_l[obase+i] !== (i == 4)) begin
        errors++;
        $display("FAIL basic_sample%0d: got %h/%0d/%b, required %h/%0d/%b", i,
                 obs_d[obase+i], obs_i[obase+i], obs_l[obase+i], xs[sbase+i], i, i == 4);
      end
    end
    checks++;
    if (zc_count !== 16'd1 || (done_pulses - dbase) != 1 ||
        (done_cyc - last_pop_cyc) < 1 || (done_cyc - last_pop_cyc) > 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: zc=%0d pulses=%0d pop_to_done=%0d busy=%b, required 1 1 1..2 0",
               zc_count, done_pulses - dbase, done_cyc - last_pop_cyc, busy);
    end
    tick(5);
    checks++;
    if (zc_count !== 16'd1) begin
      errors++;
      $display("FAIL zc_hold: got %0d required 1", zc_count);
    end
  endtask

  task automatic test_backpressure();
    int sbase, obase, dbase;
    bit ok;
    sbase = start_cnt; obase = obs_d.size(); dbase = done_pulses;
    for (int i = 0; i < 20; i++) xs[sbase+i] = $urandom;
    lat_lo = 1; lat_hi = 5; sticky = 1'b0; m_ready = 1'b0;
    pulse_run(20);
    tick(400);
    checks++;
    if ((start_cnt - sbase) != DEPTH || m_valid !== 1'b1 || busy !== 1'b1 ||
        m_index !== '0 || m_data !== xs[sbase]) begin
      errors++;
      $display("FAIL bp_stall: starts=%0d valid=%b busy=%b head=%h/%0d, required %0d 1 1 %h/0",
               start_cnt - sbase, m_valid, busy, m_data, m_index, DEPTH, xs[sbase]);
    end
    tick(7);
    checks++;
    if ((start_cnt - sbase) != DEPTH || m_valid !== 1'b1 || m_index !== '0 || m_data !== xs[sbase]) begin
      errors++;
      $display("FAIL bp_hold: starts=%0d valid=%b head=%h/%0d, required %0d 1 %h/0",
               start_cnt - sbase, m_valid, m_data, m_index, DEPTH, xs[sbase]);
    end
    m_ready = 1'b1;
    wait_done(dbase, 400, ok);
    tick(2);
    checks++;
    if (!ok || (start_cnt - sbase) != 20 || (obs_d.size() - obase) != 20) begin
      errors++;
      $display("FAIL bp_counts: done=%b starts=%0d samples=%0d, required 1 20 20",
               ok, start_cnt - sbase, obs_d.size() - obase);
    end
    for (int i = 0; i < 20 && (obase + i) < obs_d.size(); i++) begin
      checks++;
      if (obs_d[obase+i] !== xs[sbase+i] || obs_i[obase+i] !== CNT_W'(i) || obs_l[obase+i] !== (i == 19)) begin
        errors++;
        $display("FAIL bp_sample%0d: got %h/%0d/%b, required %h/%0d/%b", i,
                 obs_d[obase+i], obs_i[obase+i], obs_l[obase+i], xs[sbase+i], i, i == 19);
      end
    end
  endtask

  task automatic test_random(input bit use_sticky, input int iters);
    int sbase, obase, dbase, n;
    bit ok;
    for (int it = 0; it < iters; it++) begin
      n = int'($urandom_range(12, 1));
      sbase = start_cnt; obase = obs_d.size(); dbase = done_pulses;
      for (int i = 0; i < n; i++) xs[sbase+i] = $urandom;
      lat_lo = 1; lat_hi = use_sticky ? 3 : 6; sticky = use_sticky; m_ready = 1'b1;
      pulse_run(n);
      ok = 1'b0;
      for (int k = 0; k < 1000 && !ok; k++) begin
        m_ready = use_sticky ? 1'b1 : 1'($urandom_range(1, 0));
        tick(1);
        if (done_pulses > dbase) ok = 1'b1;
      end
      m_ready = 1'b1;
      sticky = 1'b0;
      tick(2);
      checks++;
      if (!ok || (start_cnt - sbase) != n || (obs_d.size() - obase) != n ||
          zc_count !== CNT_W'(zc_model(sbase, n))) begin
        errors++;
        $display("FAIL rand%0d_sticky%0d: done=%b starts=%0d samples=%0d zc=%0d, required 1 %0d %0d %0d",
                 it, use_sticky, ok, start_cnt - sbase, obs_d.size() - obase, zc_count, n, n, zc_model(sbase, n));
      end
      for (int i = 0; i < n && (obase + i) < obs_d.size(); i++) begin
        checks++;
        if (obs_d[obase+i] !== xs[sbase+i] || obs_i[obase+i] !== CNT_W'(i) || obs_l[obase+i] !== (i == n - 1)) begin
          errors++;
          $display("FAIL rand%0d_sample%0d: got %h/%0d/%b, required %h/%0d/%b", it, i,
                   obs_d[obase+i], obs_i[obase+i], obs_l[obase+i], xs[sbase+i], i, i == n - 1);
        end
      end
    end
  endtask

  task automatic test_zero_steps();
    int sbase, vbase, dbase, c0;
    sbase = start_cnt; vbase = valid_cyc; dbase = done_pulses;
    m_ready = 1'b1;
    num_steps = '0;
    run = 1'b1;
    c0 = cyc;
    tick(1);
    run = 1'b0;
    tick(6);
    checks++;
    if (start_cnt != sbase || valid_cyc != vbase || (done_pulses - dbase) != 1 ||
        (done_cyc - c0) < 1 || (done_cyc - c0) > 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_steps: starts=%0d valids=%0d pulses=%0d delay=%0d busy=%b, required 0 0 1 1..2 0",
               start_cnt - sbase, valid_cyc - vbase, done_pulses - dbase, done_cyc - c0, busy);
    end
  endtask

  task automatic test_abort();
    int sbase, obase, dbase, vbase;
    sbase = start_cnt; dbase = done_pulses;
    for (int i = 0; i < 10; i++) xs[sbase+i] = $urandom;
    lat_lo = 3; lat_hi = 3; sticky = 1'b0; m_ready = 1'b0;
    pulse_run(10);
    for (int k = 0; k < 200 && (start_cnt - sbase) < 4; k++) tick(1);
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || (start_cnt - sbase) != 4) begin
      errors++;
      $display("FAIL abort_pre: valid=%b busy=%b starts=%0d, required 1 1 4",
               m_valid, busy, start_cnt - sbase);
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || run_done !== 1'b1 || vdp_start !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush: valid=%b run_done=%b start=%b, required 0 1 0", m_valid, run_done, vdp_start);
    end
    vbase = valid_cyc;
    tick(1);
    checks++;
    if (busy !== 1'b0 || run_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b run_done=%b, required 0 0", busy, run_done);
    end
    m_ready = 1'b1;
    tick(12);
    checks++;
    if (valid_cyc != vbase || (start_cnt - sbase) != 4 || (done_pulses - dbase) != 1) begin
      errors++;
      $display("FAIL abort_after: valids=%0d starts=%0d pulses=%0d, required 0 4 1",
               valid_cyc - vbase, start_cnt - sbase, done_pulses - dbase);
    end
    // abort landing on the same cycle as vdp_done: that sample is dropped
    sbase = start_cnt; obase = obs_d.size(); dbase = done_pulses;
    for (int i = 0; i < 4; i++) xs[sbase+i] = $urandom | 32'h1;
    lat_lo = 2; lat_hi = 2;
    pulse_run(4);
    for (int k = 0; k < 200 && !(vdp_done === 1'b1 && (start_cnt - sbase) == 2); k++) tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    vbase = valid_cyc;
    tick(10);
    checks++;
    if (valid_cyc != vbase || (obs_d.size() - obase) != 1 || (done_pulses - dbase) != 1 ||
        (start_cnt - sbase) != 2) begin
      errors++;
      $display("FAIL abort_done_same_cycle: valids=%0d samples=%0d pulses=%0d starts=%0d, required 0 1 1 2",
               valid_cyc - vbase, obs_d.size() - obase, done_pulses - dbase, start_cnt - sbase);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random(1'b0, 4);
    test_random(1'b1, 3);
    test_zero_steps();
    test_abort();
    test_basic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
